core2wb: RTL and testbench
==========================

Name: core2wb

Overview:
- Converts an Ibex-style core data/instruction port (req/gnt/rvalid protocol) into a pipelined Wishbone B4 master.
- Sits directly upstream of the Wishbone interconnect; its transactions are consumed by Wishbone slaves such as the debug-module bridge.
- Tracks outstanding transactions and returns exactly one response per granted request.
- A bus-hang watchdog aborts the cycle and flushes outstanding requests with error responses.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_OUT, 2, maximum outstanding (granted, unanswered) transactions; range 1..15.
- TIMEOUT, 255, cycles without a response while outstanding > 0 before abort; must be at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- core_req  in  1  core request.
- core_gnt  out  1  request accepted this cycle.
- core_we  in  1  write enable.
- core_addr  in  AW  byte address.
- core_be  in  DW/8  byte enables.
- core_wdata  in  DW  write data.
- core_rvalid  out  1  response valid.
- core_rdata  out  DW  read data, valid with core_rvalid.
- core_err  out  1  error response, valid with core_rvalid.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  Wishbone write.
- wb_adr  out  AW  Wishbone address, mirrors core_addr.
- wb_sel  out  DW/8  Wishbone select, mirrors core_be.
- wb_dat_o  out  DW  Wishbone write data, mirrors core_wdata.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack  in  1  Wishbone acknowledge.
- wb_err  in  1  Wishbone error.
- wb_stall  in  1  Wishbone stall.

Behaviour:
- State machine: states IDLE (outstanding == 0), BUSY (outstanding > 0), FLUSH.
- Registered state after reset: state = IDLE, outstanding = 0, watchdog = 0.
- Outputs during reset: wb_cyc, wb_stb, core_gnt, core_rvalid and core_err are 0. Ports wb_we/adr/sel/dat_o follow core inputs.
- Request path, combinational:
  - can_issue = state != FLUSH && outstanding < MAX_OUT.
  - wb_stb = core_req & can_issue.
  - core_gnt = wb_stb & !wb_stall.
  - Capacity uses the registered count only; a same-cycle response does not free a slot.
- wb_cyc = wb_stb | (state == BUSY). It deasserts in the cycle after the last response if no new request issues.
- Response path, combinational pass-through:
  - resp = (wb_ack | wb_err) & (outstanding != 0) & state != FLUSH.
  - core_rvalid = resp; core_err = resp & wb_err; core_rdata = wb_dat_i.
  - Minimum latency: gnt in cycle N, earliest rvalid in cycle N+1.
  - Simultaneous ack and err counts as one error response.
  - ack/err while outstanding == 0 (spurious, or late after an abort) is dropped; no core_rvalid.
- Outstanding counter:
  - +1 on gnt, -1 on resp; both in the same cycle leaves it unchanged.
  - Never wraps; overflow is impossible by the can_issue gating.
- Watchdog:
  - Clears to 0 on any gnt or resp, and whenever outstanding == 0.
  - Increments in BUSY otherwise.
  - On reaching TIMEOUT-1 with no response that cycle, the next state is FLUSH.
- FLUSH:
  - wb_cyc = 0 and wb_stb = 0 (Wishbone abort); no grants.
  - Each cycle emits core_rvalid = 1, core_err = 1, core_rdata = 0, and decrements outstanding.
  - When outstanding reaches 0 the state returns to IDLE.
  - wb_ack/wb_err are ignored.
- Reset mid-operation: outstanding and state clear on the next edge. Later slave responses are spurious and dropped; no response is owed to the core.

Test Plan:
- Single read: addr=0x100, slave acks 1 cycle after stb with dat_i=0xDEADBEEF -> gnt in cycle N, rvalid=1, rdata=0xDEADBEEF, err=0 in N+1; wb_cyc low in N+2.
- Pipelined with stall: 3 back-to-back writes, wb_stall=1 for 2 cycles on the 2nd -> gnt withheld during the stall, stb held with stable adr/sel/dat_o, exactly 3 rvalids in order, outstanding never exceeds 2.
- MAX_OUT limit: slave delays acks 5 cycles, core_req held -> only 2 grants, then stb=0 until the first ack; a same-cycle ack does not allow a grant.
- Error and spurious responses:
  - wb_err on the 2nd of 2 reads -> rvalid with err=0, then err=1.
  - A stray wb_ack with outstanding == 0 -> no rvalid.
- Timeout: TIMEOUT=8, 2 outstanding, slave silent -> after 8 response-free cycles cyc drops, 2 consecutive rvalid+err pulses, state IDLE, a later ack is ignored.
- Reset mid-op: rst=1 with 2 outstanding -> next cycle cyc=0, gnt=0, outstanding=0; an ack arriving after reset produces no rvalid.

Source files
------------

// File: rtl/core2wb.sv
// core2wb: Ibex-style req/gnt/rvalid port to pipelined Wishbone B4 master.
// Tracks outstanding transfers; a bus-hang watchdog flushes them as errors.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   core_req/gnt/we      core request handshake and write flag
//   core_addr/be/wdata   core request payload (mirrored onto wb_adr/sel/dat_o)
//   core_rvalid/rdata    core response, with core_err for error responses
//   wb_cyc/stb/we        Wishbone master control
//   wb_adr/sel/dat_o     Wishbone request payload
//   wb_dat_i/ack/err     Wishbone response
//   wb_stall             Wishbone pipeline stall
module core2wb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req,
  output logic            core_gnt,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW/8-1:0] core_be,
  input  logic [DW-1:0]   core_wdata,
  output logic            core_rvalid,
  output logic [DW-1:0]   core_rdata,
  output logic            core_err,
  output logic            wb_cyc,
  output logic            wb_stb,
  output logic            wb_we,
  output logic [AW-1:0]   wb_adr,
  output logic [DW/8-1:0] wb_sel,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack,
  input  logic            wb_err,
  input  logic            wb_stall
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] CMAX  = CW'(MAX_OUT);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [WW-1:0] wdog_q;
  logic [WW-1:0] wdog_d;

  logic can_issue;
  logic stb;
  logic gnt;
  logic resp;
  logic flush;
  logic timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    state_d = state_q;
    timeout = 1'b0;

    // Flush drains one entry per cycle;
    // otherwise gnt and resp cancel out.
    if (flush) begin
      cnt_d = cnt_q - CONE;
    end else if (gnt && !resp) begin
      cnt_d = cnt_q + CONE;
    end else if (!gnt && resp) begin
      cnt_d = cnt_q - CONE;
    end

    if (gnt || resp || cnt_q == '0) begin
      wdog_d = '0;
    end else if (state_q == BUSY) begin
      wdog_d = wdog_q + WW'(1);
    end else begin
      wdog_d = '0;
    end

    if (state_q == BUSY && wdog_q == WLAST &&
        !resp && !gnt) begin
      timeout = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (gnt) state_d = BUSY;
      end
      BUSY: begin
        if (timeout) begin
          state_d = FLUSH;
          wdog_d  = '0;
        end else if (cnt_d == '0) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_q <= CONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; every control output is held low during reset
  always_comb begin
    can_issue = (state_q != FLUSH) && (cnt_q < CMAX);
    stb       = core_req & can_issue & ~rst;
    gnt       = stb & ~wb_stall;
    flush     = (state_q == FLUSH) & ~rst;
    // Responses with nothing outstanding are late or stray: drop them.
    resp      = (wb_ack | wb_err) & (cnt_q != '0) &
                (state_q != FLUSH) & ~rst;

    wb_stb      = stb;
    wb_cyc      = stb | ((state_q == BUSY) & ~rst);
    core_gnt    = gnt;
    core_rvalid = resp | flush;
    core_err    = (resp & wb_err) | flush;
    core_rdata  = flush ? '0 : wb_dat_i;
  end

  assign wb_we    = core_we;
  assign wb_adr   = core_addr;
  assign wb_sel   = core_be;
  assign wb_dat_o = core_wdata;

endmodule

// File: tb/tb_core2wb.sv
// tb_core2wb: directed self-checking bench for core2wb.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_core2wb;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_gnt;
  logic        core_we;
  logic [31:0] core_addr;
  logic [3:0]  core_be;
  logic [31:0] core_wdata;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;

  int tests;
  int fails;

  core2wb #(
    .AW(32), .DW(32), .MAX_OUT(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt),
    .core_we(core_we), .core_addr(core_addr),
    .core_be(core_be), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; core_req = 1'b1; core_we = 1'b1;
    core_addr = 32'h44; core_be = 4'h5;
    core_wdata = 32'h1234; wb_ack = 1'b1;
    wb_err = 1'b1; wb_stall = 1'b0; wb_dat_i = '0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0) begin fails++;
      $display("FAIL rst_cyc got %b want 0", wb_cyc); end
    tests++; if (wb_stb !== 1'b0) begin fails++;
      $display("FAIL rst_stb got %b want 0", wb_stb); end
    tests++; if (core_gnt !== 1'b0) begin fails++;
      $display("FAIL rst_gnt got %b want 0", core_gnt); end
    tests++; if (core_rvalid !== 1'b0) begin fails++;
      $display("FAIL rst_rvalid got %b want 0", core_rvalid); end
    tests++; if (core_err !== 1'b0) begin fails++;
      $display("FAIL rst_err got %b want 0", core_err); end
    tests++; if (wb_adr !== 32'h44 || wb_sel !== 4'h5 ||
                 wb_dat_o !== 32'h1234 || wb_we !== 1'b1) begin
      fails++;
      $display("FAIL rst_mirror got %h/%h/%h/%b want 44/5/1234/1",
               wb_adr, wb_sel, wb_dat_o, wb_we);
    end
    tick();
    rst = 1'b0; core_req = 1'b0; core_we = 1'b0;
    wb_ack = 1'b0; wb_err = 1'b0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0) begin fails++;
      $display("FAIL post_rst_cyc got %b want 0", wb_cyc); end
  endtask

  task automatic test_single_read();
    tick();
    core_req = 1'b1; core_we = 1'b0;
    core_addr = 32'h100; core_be = 4'hf;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1 || wb_stb !== 1'b1 ||
                 wb_cyc !== 1'b1) begin fails++;
      $display("FAIL rd_gnt got gnt=%b stb=%b cyc=%b want 1/1/1",
               core_gnt, wb_stb, wb_cyc); end
    tests++; if (wb_adr !== 32'h100 || wb_we !== 1'b0) begin
      fails++;
      $display("FAIL rd_adr got %h we=%b want 100 we=0",
               wb_adr, wb_we); end
    tick();
    core_req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1 || core_err !== 1'b0) begin
      fails++;
      $display("FAIL rd_rvalid got rv=%b err=%b want 1/0",
               core_rvalid, core_err); end
    tests++; if (core_rdata !== 32'hDEADBEEF) begin fails++;
      $display("FAIL rd_rdata got %h want deadbeef", core_rdata); end
    tick();
    wb_ack = 1'b0; wb_dat_i = '0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0 || core_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rd_cyc_drop got cyc=%b rv=%b want 0/0",
               wb_cyc, core_rvalid); end
  endtask

  task automatic test_stall();
    int nrv;
    nrv = 0;
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h300;
    core_be = 4'h3; core_wdata = 32'hA0;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1 || wb_we !== 1'b1 ||
                 wb_sel !== 4'h3 || wb_dat_o !== 32'hA0) begin
      fails++;
      $display("FAIL st_w0 got gnt=%b we=%b sel=%h dat=%h",
               core_gnt, wb_we, wb_sel, wb_dat_o); end
    tick();
    core_addr = 32'h304; core_be = 4'hc; core_wdata = 32'hA1;
    wb_stall = 1'b1; wb_ack = 1'b1;
    @(negedge clk);
    nrv += int'(core_rvalid);
    tests++; if (core_gnt !== 1'b0 || wb_stb !== 1'b1 ||
                 core_rvalid !== 1'b1) begin fails++;
      $display("FAIL st_stall1 got gnt=%b stb=%b rv=%b want 0/1/1",
               core_gnt, wb_stb, core_rvalid); end
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    nrv += int'(core_rvalid);
    tests++; if (core_gnt !== 1'b0 || wb_stb !== 1'b1 ||
                 wb_cyc !== 1'b1 || core_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL st_stall2 got gnt=%b stb=%b cyc=%b rv=%b",
               core_gnt, wb_stb, wb_cyc, core_rvalid); end
    tests++; if (wb_adr !== 32'h304 || wb_sel !== 4'hc ||
                 wb_dat_o !== 32'hA1) begin fails++;
      $display("FAIL st_hold got %h/%h/%h want 304/c/a1",
               wb_adr, wb_sel, wb_dat_o); end
    tick();
    wb_stall = 1'b0;
    @(negedge clk);
    nrv += int'(core_rvalid);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL st_w1 got gnt=%b want 1", core_gnt); end
    tick();
    core_addr = 32'h308; core_be = 4'hf; core_wdata = 32'hA2;
    wb_ack = 1'b1;
    @(negedge clk);
    nrv += int'(core_rvalid);
    tests++; if (core_gnt !== 1'b1 || core_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL st_w2 got gnt=%b rv=%b want 1/1",
               core_gnt, core_rvalid); end
    tick();
    core_req = 1'b0; core_we = 1'b0;
    @(negedge clk);
    nrv += int'(core_rvalid);
    tests++; if (core_rvalid !== 1'b1 || core_gnt !== 1'b0) begin
      fails++;
      $display("FAIL st_r2 got rv=%b gnt=%b want 1/0",
               core_rvalid, core_gnt); end
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    nrv += int'(core_rvalid);
    tests++; if (wb_cyc !== 1'b0) begin fails++;
      $display("FAIL st_cyc got %b want 0", wb_cyc); end
    tests++; if (nrv !== 3) begin fails++;
      $display("FAIL st_count got %0d rvalids want 3", nrv); end
  endtask

  task automatic test_max_out();
    tick();
    core_req = 1'b1; core_addr = 32'h600;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL mo_g0 got %b want 1", core_gnt); end
    tick();
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL mo_g1 got %b want 1", core_gnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      tests++; if (wb_stb !== 1'b0 || core_gnt !== 1'b0 ||
                   wb_cyc !== 1'b1) begin fails++;
        $display("FAIL mo_full%0d got stb=%b gnt=%b cyc=%b", i,
                 wb_stb, core_gnt, wb_cyc); end
    end
    tick();
    wb_ack = 1'b1;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1 || core_gnt !== 1'b0 ||
                 wb_stb !== 1'b0) begin fails++;
      $display("FAIL mo_sameack got rv=%b gnt=%b stb=%b want 1/0/0",
               core_rvalid, core_gnt, wb_stb); end
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL mo_refill got %b want 1", core_gnt); end
    tick();
    core_req = 1'b0; wb_ack = 1'b1;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1) begin fails++;
      $display("FAIL mo_d0 got %b want 1", core_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1) begin fails++;
      $display("FAIL mo_d1 got %b want 1", core_rvalid); end
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0) begin fails++;
      $display("FAIL mo_cyc got %b want 0", wb_cyc); end
  endtask

  task automatic test_error();
    tick();
    core_req = 1'b1; core_addr = 32'h200;
    tick();
    core_addr = 32'h204;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL er_g1 got %b want 1", core_gnt); end
    tick();
    core_req = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h11;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1 || core_err !== 1'b0 ||
                 core_rdata !== 32'h11) begin fails++;
      $display("FAIL er_ok got rv=%b err=%b d=%h want 1/0/11",
               core_rvalid, core_err, core_rdata); end
    tick();
    wb_err = 1'b1;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1 || core_err !== 1'b1) begin
      fails++;
      $display("FAIL er_err got rv=%b err=%b want 1/1",
               core_rvalid, core_err); end
    tick();
    wb_err = 1'b0; wb_dat_i = '0;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b0 || wb_cyc !== 1'b0) begin
      fails++;
      $display("FAIL er_stray got rv=%b cyc=%b want 0/0",
               core_rvalid, wb_cyc); end
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    core_req = 1'b1; core_addr = 32'h400;
    tick();
    core_addr = 32'h404;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL to_g1 got %b want 1", core_gnt); end
    for (int i = 0; i < 8; i++) begin
      tick();
      core_req = 1'b0;
      @(negedge clk);
      tests++; if (wb_cyc !== 1'b1 || core_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL to_wait%0d got cyc=%b rv=%b want 1/0", i,
                 wb_cyc, core_rvalid); end
    end
    tick();
    core_req = 1'b1; wb_ack = 1'b1; wb_dat_i = 32'h5555;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 ||
                 core_gnt !== 1'b0) begin fails++;
      $display("FAIL to_abort got cyc=%b stb=%b gnt=%b want 0/0/0",
               wb_cyc, wb_stb, core_gnt); end
    tests++; if (core_rvalid !== 1'b1 || core_err !== 1'b1 ||
                 core_rdata !== 32'h0) begin fails++;
      $display("FAIL to_fl0 got rv=%b err=%b d=%h want 1/1/0",
               core_rvalid, core_err, core_rdata); end
    tick();
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1 || core_err !== 1'b1 ||
                 wb_cyc !== 1'b0 || core_gnt !== 1'b0) begin
      fails++;
      $display("FAIL to_fl1 got rv=%b err=%b cyc=%b gnt=%b",
               core_rvalid, core_err, wb_cyc, core_gnt); end
    tick();
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b0 || core_gnt !== 1'b1) begin
      fails++;
      $display("FAIL to_idle got rv=%b gnt=%b want 0/1",
               core_rvalid, core_gnt); end
    tick();
    core_req = 1'b0; wb_dat_i = 32'h77;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1 || core_err !== 1'b0 ||
                 core_rdata !== 32'h77) begin fails++;
      $display("FAIL to_after got rv=%b err=%b d=%h want 1/0/77",
               core_rvalid, core_err, core_rdata); end
    tick();
    wb_ack = 1'b0; wb_dat_i = '0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0) begin fails++;
      $display("FAIL to_cyc got %b want 0", wb_cyc); end
  endtask

  task automatic test_reset_midop();
    tick();
    core_req = 1'b1; core_addr = 32'h500;
    tick();
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL rm_g1 got %b want 1", core_gnt); end
    tick();
    core_req = 1'b0; rst = 1'b1; wb_ack = 1'b1;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0 || core_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rm_inrst got cyc=%b rv=%b want 0/0",
               wb_cyc, core_rvalid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0 || core_gnt !== 1'b0 ||
                 core_rvalid !== 1'b0) begin fails++;
      $display("FAIL rm_late got cyc=%b gnt=%b rv=%b want 0/0/0",
               wb_cyc, core_gnt, core_rvalid); end
    tick();
    wb_ack = 1'b0; core_req = 1'b1;
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL rm_g2 got %b want 1", core_gnt); end
    tick();
    @(negedge clk);
    tests++; if (core_gnt !== 1'b1) begin fails++;
      $display("FAIL rm_g3 got %b want 1", core_gnt); end
    tick();
    core_req = 1'b0; wb_ack = 1'b1;
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1) begin fails++;
      $display("FAIL rm_r0 got %b want 1", core_rvalid); end
    tick();
    @(negedge clk);
    tests++; if (core_rvalid !== 1'b1) begin fails++;
      $display("FAIL rm_r1 got %b want 1", core_rvalid); end
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    tests++; if (wb_cyc !== 1'b0) begin fails++;
      $display("FAIL rm_cyc got %b want 0", wb_cyc); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_read();
    test_stall();
    test_max_out();
    test_error();
    test_timeout();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
